// File: rtl/upcounter_pkg.sv
// Shared definitions for the UpCounter run/step/clear sequencer.
// State encodings are fixed because the state output is observed directly.
package upcounter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    localparam int WIDTH_DEF = 12;

    // Divider register width; covers the full TICK_DIV range of 2..65535.
    localparam int DIV_W = 16;

endpackage

// File: rtl/upcounter_ctrl_btn_edge.sv
// Rising-edge detector for a level push-button input.
// The history register resets to RST_VAL so that a button held through reset produces no edge.
module btn_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic edge_pulse
);

    logic btn_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d <= RST_VAL;
        end else begin
            btn_d <= btn;
        end
    end

    assign edge_pulse = btn & ~btn_d;

endmodule

// File: rtl/upcounter_ctrl.sv
// Run/step/clear sequencer that turns push-button levels into single-cycle
// enable/clear pulses for a WIDTH-bit up-counter, stopping at a terminal count.
module upcounter_ctrl
    import upcounter_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_btn,
    input  logic             stop_btn,
    input  logic             step_btn,
    input  logic             clr_btn,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] q,
    output logic             cnt_en,
    output logic             cnt_rst,
    output logic [1:0]       state,
    output logic             done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t           cur_state;
    state_t           nxt_state;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             en_nxt;
    logic             clr_nxt;

    logic start_edge;
    logic stop_edge;
    logic step_edge;
    logic clr_edge;

    btn_edge #(.RST_VAL(1'b1)) u_start_edge (
        .clk        (clk),
        .rst        (rst),
        .btn        (start_btn),
        .edge_pulse (start_edge)
    );

    btn_edge #(.RST_VAL(1'b1)) u_stop_edge (
        .clk        (clk),
        .rst        (rst),
        .btn        (stop_btn),
        .edge_pulse (stop_edge)
    );

    btn_edge #(.RST_VAL(1'b1)) u_step_edge (
        .clk        (clk),
        .rst        (rst),
        .btn        (step_btn),
        .edge_pulse (step_edge)
    );

    btn_edge #(.RST_VAL(1'b1)) u_clr_edge (
        .clk        (clk),
        .rst        (rst),
        .btn        (clr_btn),
        .edge_pulse (clr_edge)
    );

    // Only the highest-priority event of a cycle survives (clr > stop > start > step).
    logic start_evt;
    logic step_evt;
    logic at_limit;

    assign start_evt = start_edge & ~stop_edge;
    assign step_evt  = step_edge & ~stop_edge & ~start_edge;
    assign at_limit  = (q == limit);

    always_comb begin
        nxt_state = cur_state;
        div_nxt   = div;
        en_nxt    = 1'b0;
        clr_nxt   = 1'b0;

        if (clr_edge) begin
            nxt_state = ST_IDLE;
            div_nxt   = '0;
            clr_nxt   = 1'b1;
        end else begin
            unique case (cur_state)
                ST_IDLE, ST_PAUSE: begin
                    if (at_limit) begin
                        nxt_state = ST_DONE;
                    end else if (start_evt) begin
                        nxt_state = ST_RUN;
                        div_nxt   = '0;
                    end else if (step_evt) begin
                        en_nxt = 1'b1;
                    end
                end
                ST_RUN: begin
                    // A stop freezes the divider; the next RUN entry clears it.
                    if (at_limit) begin
                        nxt_state = ST_DONE;
                    end else if (stop_edge) begin
                        nxt_state = ST_PAUSE;
                    end else if (div == DIV_LAST) begin
                        div_nxt = '0;
                        en_nxt  = 1'b1;
                    end else begin
                        div_nxt = div + 1'b1;
                    end
                end
                ST_DONE: begin
                    nxt_state = ST_DONE;
                end
                default: begin
                    nxt_state = ST_IDLE;
                    div_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= ST_IDLE;
            div       <= '0;
            cnt_en    <= 1'b0;
            cnt_rst   <= 1'b1;
            done      <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            div       <= div_nxt;
            cnt_en    <= en_nxt;
            cnt_rst   <= clr_nxt;
            done      <= (nxt_state == ST_DONE);
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_upcounter_ctrl.sv
// Bench for upcounter_ctrl driving a behavioural 12-bit up-counter from its outputs.
// Enable pulses are matched against a queue of expected pulse cycles.
module tb_upcounter_ctrl;

    localparam int W = 12;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_btn = 1'b0;
    logic         stop_btn = 1'b0;
    logic         step_btn = 1'b0;
    logic         clr_btn = 1'b0;
    logic [W-1:0] limit = 12'd100;
    logic [W-1:0] q;
    logic         cnt_en;
    logic         cnt_rst;
    logic [1:0]   state;
    logic         done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int e;

    logic [31:0] exp_q[$];

    upcounter_ctrl #(.WIDTH(W), .TICK_DIV(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_btn (start_btn),
        .stop_btn  (stop_btn),
        .step_btn  (step_btn),
        .clr_btn   (clr_btn),
        .limit     (limit),
        .q         (q),
        .cnt_en    (cnt_en),
        .cnt_rst   (cnt_rst),
        .state     (state),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural UpCounter fed by the controller.
    always @(posedge clk) begin
        if (cnt_rst) q <= '0;
        else if (cnt_en) q <= q + 1'b1;
    end

    // Every enable pulse must match the head of the expected-cycle queue.
    always @(negedge clk) begin
        if (cnt_en === 1'b1) begin
            n_assert++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
            end else begin
                logic [31:0] t;
                t = exp_q.pop_front();
                if (t !== 32'(cyc)) begin
                    n_fail++;
                    $display("FAIL pulse_cycle: got %0d expected %0d", cyc, t);
                end
            end
        end
        if (cnt_en === 1'b1 && cnt_rst === 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL en_rst_overlap: got both high at cycle %0d expected exclusive", cyc);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge: buttons high for one cycle, edge sampled at cyc+1.
    task automatic press(input logic s_start, input logic s_stop,
                         input logic s_step, input logic s_clr);
        start_btn = s_start;
        stop_btn  = s_stop;
        step_btn  = s_step;
        clr_btn   = s_clr;
        @(negedge clk);
        start_btn = 1'b0;
        stop_btn  = 1'b0;
        step_btn  = 1'b0;
        clr_btn   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step_btn = 1'b1;
        limit = 12'd100;
        wait_cyc(3);
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
        n_assert++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_en: got %0b expected 0", cnt_en); end
        n_assert++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_rst: got %0b expected 1", cnt_rst); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL rst_release_cnt_rst: got %0b expected 0", cnt_rst); end
        wait_cyc(4);
        step_btn = 1'b0;
        wait_cyc(2);
        exp_q.push_back(32'(cyc + 1));
        press(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(2);
        n_assert++; if (q !== 12'd1) begin n_fail++; $display("FAIL held_step_q: got %0d expected 1", q); end
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL held_step_state: got %0d expected 0", state); end
    endtask

    task automatic test_run_to_limit;
        limit = 12'd5;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        n_assert++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got %0b expected 1", cnt_rst); end
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL clr_state: got %0d expected 0", state); end
        wait_cyc(1);
        n_assert++; if (q !== 12'd0) begin n_fail++; $display("FAIL clr_q: got %0d expected 0", q); end
        n_assert++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL clr_single: got %0b expected 0", cnt_rst); end
        e = cyc + 1;
        for (int i = 1; i <= 5; i++) exp_q.push_back(32'(e + 4 * i));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        n_assert++; if (state !== 2'b01) begin n_fail++; $display("FAIL run_entry: got %0d expected 1", state); end
        wait_cyc(24);
        n_assert++; if (q !== 12'd5) begin n_fail++; $display("FAIL limit_q: got %0d expected 5", q); end
        n_assert++; if (state !== 2'b11) begin n_fail++; $display("FAIL limit_state: got %0d expected 3", state); end
        n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL limit_done: got %0b expected 1", done); end
        wait_cyc(6);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(6);
        n_assert++; if (state !== 2'b11) begin n_fail++; $display("FAIL done_sticky: got %0d expected 3", state); end
        n_assert++; if (q !== 12'd5) begin n_fail++; $display("FAIL done_no_overshoot: got %0d expected 5", q); end
    endtask

    task automatic test_pause_resume;
        limit = 12'd100;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL done_clr_state: got %0d expected 0", state); end
        n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_clr_done: got %0b expected 0", done); end
        wait_cyc(1);
        e = cyc + 1;
        exp_q.push_back(32'(e + 4));
        exp_q.push_back(32'(e + 8));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(9);
        n_assert++; if (q !== 12'd2) begin n_fail++; $display("FAIL run_q2: got %0d expected 2", q); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_assert++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_entry: got %0d expected 2", state); end
        wait_cyc(20);
        n_assert++; if (q !== 12'd2) begin n_fail++; $display("FAIL pause_hold_q: got %0d expected 2", q); end
        n_assert++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_hold_state: got %0d expected 2", state); end
        e = cyc + 1;
        exp_q.push_back(32'(e + 4));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(5);
        n_assert++; if (q !== 12'd3) begin n_fail++; $display("FAIL resume_q: got %0d expected 3", q); end
        n_assert++; if (state !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %0d expected 1", state); end
        press(1'b0, 1'b1, 1'b0, 1'b0);
        n_assert++; if (state !== 2'b10) begin n_fail++; $display("FAIL pause_again: got %0d expected 2", state); end
    endtask

    task automatic test_step_pause;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'(cyc + 1));
            press(1'b0, 1'b0, 1'b1, 1'b0);
            wait_cyc(1);
        end
        n_assert++; if (q !== 12'd6) begin n_fail++; $display("FAIL step_q: got %0d expected 6", q); end
        n_assert++; if (state !== 2'b10) begin n_fail++; $display("FAIL step_state: got %0d expected 2", state); end
    endtask

    task automatic test_clr_start_same;
        e = cyc + 1;
        exp_q.push_back(32'(e + 4));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(5);
        n_assert++; if (q !== 12'd7) begin n_fail++; $display("FAIL pre_clr_q: got %0d expected 7", q); end
        press(1'b1, 1'b0, 1'b0, 1'b1);
        n_assert++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL same_cnt_rst: got %0b expected 1", cnt_rst); end
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL same_state: got %0d expected 0", state); end
        wait_cyc(1);
        n_assert++; if (q !== 12'd0) begin n_fail++; $display("FAIL same_q: got %0d expected 0", q); end
        wait_cyc(8);
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL same_no_run: got %0d expected 0", state); end
    endtask

    task automatic test_rst_mid_run;
        press(1'b1, 1'b0, 1'b0, 1'b0);
        wait_cyc(2);
        rst = 1'b1;
        @(negedge clk);
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", state); end
        n_assert++; if (cnt_en !== 1'b0) begin n_fail++; $display("FAIL midrst_cnt_en: got %0b expected 0", cnt_en); end
        n_assert++; if (cnt_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_cnt_rst: got %0b expected 1", cnt_rst); end
        rst = 1'b0;
        @(negedge clk);
        n_assert++; if (q !== 12'd0) begin n_fail++; $display("FAIL midrst_q: got %0d expected 0", q); end
        n_assert++; if (cnt_rst !== 1'b0) begin n_fail++; $display("FAIL midrst_release: got %0b expected 0", cnt_rst); end
        wait_cyc(6);
        n_assert++; if (state !== 2'b00) begin n_fail++; $display("FAIL midrst_idle: got %0d expected 0", state); end
    endtask

    task automatic test_limit_zero;
        limit = 12'd0;
        press(1'b0, 1'b0, 1'b0, 1'b1);
        wait_cyc(3);
        n_assert++; if (state !== 2'b11) begin n_fail++; $display("FAIL zero_state: got %0d expected 3", state); end
        n_assert++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %0b expected 1", done); end
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        wait_cyc(6);
        n_assert++; if (q !== 12'd0) begin n_fail++; $display("FAIL zero_q: got %0d expected 0", q); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_run_to_limit();
        test_pause_resume();
        test_step_pause();
        test_clr_start_same();
        test_rst_mid_run();
        test_limit_zero();
        wait_cyc(2);
        n_assert++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_pulses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
